// File: rtl/cf_fft_ctrl_pkg.sv
// Shared types and constants for the FFT control-flag sequencer.
package cf_fft_ctrl_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Slice k is the step code that selects source k.
   localparam logic [8:0] MAP_CODES_DEFAULT = {3'd6, 3'd1, 3'd3};

endpackage

// File: rtl/cf_fft_flag_decode.sv
// Combinational step-code to flag selector for one channel.
module cf_fft_flag_decode
   import cf_fft_ctrl_pkg::*;
#(
   parameter int unsigned                SEL_W       = 3,
   parameter int unsigned                NUM_STEPS   = 8,
   parameter int unsigned                NUM_SRC     = 3,
   parameter logic [NUM_SRC*SEL_W-1:0]   MAP_CODES   = MAP_CODES_DEFAULT,
   parameter logic                       DEFAULT_VAL = 1'b1
) (
   input  logic [SEL_W-1:0]   step,
   input  logic [NUM_SRC-1:0] flags,
   output logic               flag
);

   logic [NUM_SRC-1:0] hit;
   logic [NUM_SRC:0]   chain;

   assign chain[0] = DEFAULT_VAL;

   // Later sources overwrite earlier ones, so the highest matching k wins.
   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      localparam logic [SEL_W-1:0] CODE = MAP_CODES[k*SEL_W +: SEL_W];
      localparam bit               LIVE = (32'(CODE) < NUM_STEPS);

      assign hit[k]     = LIVE && (step == CODE);
      assign chain[k+1] = hit[k] ? flags[k] : chain[k];
   end

   assign flag = chain[NUM_SRC];

endmodule

// File: rtl/cf_fft_ctrl_flag_seq.sv
// Sequenced, registered flag selector: walks step codes per frame and emits the
// mapped source flag (or a default) for each channel one cycle after issue.
module cf_fft_ctrl_flag_seq
   import cf_fft_ctrl_pkg::*;
#(
   parameter int unsigned              SEL_W       = 3,
   parameter int unsigned              NUM_STEPS   = 8,
   parameter int unsigned              NUM_SRC     = 3,
   parameter int unsigned              NUM_CH      = 2,
   parameter logic [NUM_SRC*SEL_W-1:0] MAP_CODES   = MAP_CODES_DEFAULT,
   parameter logic                     DEFAULT_VAL = 1'b1,
   parameter int unsigned              FRAMES      = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_start,
   input  logic                      i_hold,
   input  logic                      i_clear,
   input  logic [NUM_CH*NUM_SRC-1:0] i_flags,
   output logic [NUM_CH-1:0]         o_flag,
   output logic                      o_valid,
   output logic [SEL_W-1:0]          o_step,
   output logic                      o_busy,
   output logic                      o_done
);

   localparam int unsigned FRW = $clog2(FRAMES + 1);

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  step_q, step_d;
   logic [FRW-1:0]    frame_q, frame_d;
   logic [NUM_CH-1:0] dec;
   logic [NUM_CH-1:0] flag_q, flag_d;
   logic [SEL_W-1:0]  ostep_q, ostep_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              last_q, last_d;
   logic              last_step, last_frame;

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      cf_fft_flag_decode #(
         .SEL_W      (SEL_W),
         .NUM_STEPS  (NUM_STEPS),
         .NUM_SRC    (NUM_SRC),
         .MAP_CODES  (MAP_CODES),
         .DEFAULT_VAL(DEFAULT_VAL)
      ) u_decode (
         .step (step_q),
         .flags(i_flags[ch*NUM_SRC +: NUM_SRC]),
         .flag (dec[ch])
      );
   end

   assign last_step  = (step_q == SEL_W'(NUM_STEPS - 1));
   assign last_frame = (frame_q == FRW'(FRAMES - 1));

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      frame_d = frame_q;
      flag_d  = flag_q;
      ostep_d = ostep_q;
      valid_d = 1'b0;
      last_d  = 1'b0;
      done_d  = last_q;
      if (i_clear) begin
         state_d = IDLE;
         step_d  = '0;
         frame_d = '0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            // busy_q is still high during the final o_valid cycle, when the FSM is already IDLE.
            IDLE: if (i_start && !i_hold && !busy_q) state_d = RUN;
            RUN: begin
               if (!i_hold) begin
                  flag_d  = dec;
                  ostep_d = step_q;
                  valid_d = 1'b1;
                  if (last_step) begin
                     step_d = '0;
                     if (last_frame) begin
                        frame_d = '0;
                        state_d = IDLE;
                        last_d  = 1'b1;
                     end else begin
                        frame_d = frame_q + FRW'(1);
                     end
                  end else begin
                     step_d = step_q + SEL_W'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d == RUN) || last_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         step_q  <= '0;
         frame_q <= '0;
         flag_q  <= '0;
         ostep_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         frame_q <= frame_d;
         flag_q  <= flag_d;
         ostep_q <= ostep_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         last_q  <= last_d;
      end
   end

   assign o_flag  = flag_q;
   assign o_valid = valid_q;
   assign o_step  = ostep_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;

endmodule

// File: tb/tb_cf_fft_ctrl_flag_seq.sv
// Scoreboard bench: three configurations driven with shared random stimulus,
// each checked against a sequence-level reference model.
module tb_cf_fft_ctrl_flag_seq;

   typedef struct {
      int         stamp;
      logic [2:0] step;
      logic [1:0] flag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       i_start = 1'b0;
   logic       i_hold = 1'b0;
   logic       i_clear = 1'b0;
   logic [5:0] i_flags = '0;
   logic [5:0] flg;
   logic [8:0] stp;
   logic [2:0] vld, bsy, dne;

   int total = 0;
   int passed = 0;

   // Per-configuration parameters: a=defaults, b=3 frames of 5, c=remapped codes.
   int ns_c [3] = '{8, 5, 6};
   int fr_c [3] = '{1, 3, 1};
   int def_c[3] = '{1, 1, 0};
   int map_c[3][3] = '{'{3, 1, 6}, '{3, 1, 6}, '{7, 2, 2}};

   int         cyc;
   bit         running  [3];
   int         pos      [3];
   bit         lastv    [3];
   bit         exp_busy [3];
   bit         exp_done [3];
   logic [1:0] last_flag[3];
   logic [2:0] last_step[3];
   exp_t       q0[$], q1[$], q2[$];

   always #5 clk = ~clk;

   cf_fft_ctrl_flag_seq u_a (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_hold(i_hold), .i_clear(i_clear),
      .i_flags(i_flags), .o_flag(flg[1:0]), .o_valid(vld[0]), .o_step(stp[2:0]),
      .o_busy(bsy[0]), .o_done(dne[0])
   );

   cf_fft_ctrl_flag_seq #(.NUM_STEPS(5), .FRAMES(3)) u_b (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_hold(i_hold), .i_clear(i_clear),
      .i_flags(i_flags), .o_flag(flg[3:2]), .o_valid(vld[1]), .o_step(stp[5:3]),
      .o_busy(bsy[1]), .o_done(dne[1])
   );

   cf_fft_ctrl_flag_seq #(
      .NUM_STEPS(6), .MAP_CODES({3'd2, 3'd2, 3'd7}), .DEFAULT_VAL(1'b0)
   ) u_c (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_hold(i_hold), .i_clear(i_clear),
      .i_flags(i_flags), .o_flag(flg[5:4]), .o_valid(vld[2]), .o_step(stp[8:6]),
      .o_busy(bsy[2]), .o_done(dne[2])
   );

   task automatic chk(input string name, input int c, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, c, cyc, act, exp);
   endtask

   function automatic int qsize(input int c);
      case (c)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic exp_t qfront(input int c);
      case (c)
         0:       return q0[0];
         1:       return q1[0];
         default: return q2[0];
      endcase
   endfunction

   task automatic qpush(input int c, input exp_t e);
      case (c)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic qpop(input int c);
      case (c)
         0:       void'(q0.pop_front());
         1:       void'(q1.pop_front());
         default: void'(q2.pop_front());
      endcase
   endtask

   // Highest-numbered source whose code is reachable and equals the step wins.
   function automatic bit ref_flag(input int c, input int s, input logic [5:0] f, input int ch);
      for (int k = 2; k >= 0; k--)
         if (map_c[c][k] < ns_c[c] && map_c[c][k] == s) return f[ch*3+k];
      return def_c[c][0];
   endfunction

   // Reference model: position counts issued steps across all frames of a run.
   initial begin
      exp_t e;
      bit   was_last, busy_now;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            cyc = 0;
            q0.delete(); q1.delete(); q2.delete();
            for (int c = 0; c < 3; c++) begin
               running[c] = 0; pos[c] = 0; lastv[c] = 0; exp_busy[c] = 0; exp_done[c] = 0;
               last_flag[c] = '0; last_step[c] = '0;
            end
         end else begin
            cyc++;
            for (int c = 0; c < 3; c++) begin
               was_last = lastv[c];
               busy_now = exp_busy[c];
               lastv[c] = 0;
               if (i_clear) begin
                  running[c] = 0;
                  pos[c] = 0;
               end else if (running[c]) begin
                  if (!i_hold) begin
                     e.stamp = cyc;
                     e.step  = 3'(pos[c] % ns_c[c]);
                     e.flag  = {ref_flag(c, pos[c] % ns_c[c], i_flags, 1),
                                ref_flag(c, pos[c] % ns_c[c], i_flags, 0)};
                     qpush(c, e);
                     last_flag[c] = e.flag;
                     last_step[c] = e.step;
                     pos[c]++;
                     if (pos[c] == ns_c[c] * fr_c[c]) begin
                        running[c] = 0;
                        pos[c] = 0;
                        lastv[c] = 1;
                     end
                  end
               end else if (i_start && !i_hold && !busy_now) begin
                  running[c] = 1;
               end
               exp_busy[c] = running[c] || lastv[c];
               exp_done[c] = was_last && !i_clear;
            end
         end
      end
   end

   // Monitor: compare DUT outputs against the model on the falling edge.
   initial begin
      exp_t e;
      bit   ev;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int c = 0; c < 3; c++) begin
               ev = (qsize(c) > 0) && (qfront(c).stamp == cyc);
               chk("busy", c, 32'(bsy[c]), 32'(exp_busy[c]));
               chk("done", c, 32'(dne[c]), 32'(exp_done[c]));
               chk("valid", c, 32'(vld[c]), 32'(ev));
               if (ev) begin
                  e = qfront(c);
                  qpop(c);
                  chk("step", c, 32'(stp[c*3 +: 3]), 32'(e.step));
                  chk("flag", c, 32'(flg[c*2 +: 2]), 32'(e.flag));
               end else begin
                  chk("held_step", c, 32'(stp[c*3 +: 3]), 32'(last_step[c]));
                  chk("held_flag", c, 32'(flg[c*2 +: 2]), 32'(last_flag[c]));
               end
            end
         end
      end
   end

   task automatic tick(input bit s, input bit h, input bit c);
      i_start = s;
      i_hold  = h;
      i_clear = c;
      i_flags = 6'($urandom);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0);
   endtask

   task automatic check_reset_outputs(input string name);
      for (int c = 0; c < 3; c++) begin
         chk({name, "_flag"}, c, 32'(flg[c*2 +: 2]), 32'd0);
         chk({name, "_step"}, c, 32'(stp[c*3 +: 3]), 32'd0);
         chk({name, "_valid"}, c, 32'(vld[c]), 32'd0);
         chk({name, "_busy"}, c, 32'(bsy[c]), 32'd0);
         chk({name, "_done"}, c, 32'(dne[c]), 32'd0);
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2 check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Plain run on every configuration.
      tick(1, 0, 0);
      idle(20);

      // Hold for three cycles around step 4.
      tick(1, 0, 0);
      idle(4);
      for (int i = 0; i < 3; i++) tick(0, 1, 0);
      idle(20);

      // Start while busy is ignored; start in the done cycle begins a new run.
      tick(1, 0, 0);
      idle(2);
      tick(1, 0, 0);
      idle(2);
      tick(1, 0, 0);
      for (int i = 0; i < 40 && !exp_done[0]; i++) tick(0, 0, 0);
      tick(1, 0, 0);
      idle(20);

      // Clear mid-run, then restart.
      tick(1, 0, 0);
      idle(3);
      tick(0, 0, 1);
      idle(20);
      tick(1, 0, 0);
      idle(20);

      // Randomised control traffic.
      for (int i = 0; i < 400; i++)
         tick(($urandom % 8) == 0, ($urandom % 6) == 0, ($urandom % 40) == 0);
      idle(20);

      // Asynchronous reset in the middle of a frame.
      tick(1, 0, 0);
      idle(7);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      @(posedge clk);
      #1 check_reset_outputs("rst_held");
      @(negedge clk);
      rst_n = 1'b1;
      tick(1, 0, 0);
      idle(25);

      for (int c = 0; c < 3; c++) chk("drain", c, 32'(qsize(c)), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
